// File: rtl/refill_merge_arb.sv
// ---------------------------------------------------------------------------
// refill_merge_arb
//
// Merges cache-line refill misses from NumInp requesters into a small
// outstanding-miss table. A winner whose line is already outstanding is
// merged into that entry (no downstream request). Otherwise a new refill is
// issued downstream, tagged with the table entry index. When a refill
// completes, every requester waiting on that entry gets a one-cycle pulse.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   flush_i      clears arbiter lock and round-robin pointer
//   inp_addr_i   per-requester line address
//   inp_valid_i  per-requester request valid
//   inp_ready_o  per-requester accept (onehot or zero)
//   oup_addr_o   downstream refill address
//   oup_id_o     table entry tagging the refill
//   oup_valid_o  downstream request valid
//   oup_ready_i  downstream accept
//   rsp_valid_i  refill-complete strobe
//   rsp_id_i     entry of the completed refill
//   rsp_done_o   completion pulse per waiting requester
//   busy_o       any table entry valid
//
// State | meaning
// ------+-------------------------------------------------------------
// ARB   | free round-robin arbitration each cycle
// HOLD  | issued miss stalled by downstream; winner and id frozen
// ---------------------------------------------------------------------------
module refill_merge_arb #(
    parameter int NumInp     = 4,
    parameter int AddrWidth  = 32,
    parameter int NumEntries = 4,
    parameter int IdWidth    = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic [NumInp-1:0][AddrWidth-1:0]  inp_addr_i,
    input  logic [NumInp-1:0]                 inp_valid_i,
    output logic [NumInp-1:0]                 inp_ready_o,
    output logic [AddrWidth-1:0]              oup_addr_o,
    output logic [IdWidth-1:0]                oup_id_o,
    output logic                              oup_valid_o,
    input  logic                              oup_ready_i,
    input  logic                              rsp_valid_i,
    input  logic [IdWidth-1:0]                rsp_id_i,
    output logic [NumInp-1:0]                 rsp_done_o,
    output logic                              busy_o
);

    localparam int PtrW = (NumInp > 1) ? $clog2(NumInp) : 1;

    typedef enum logic {ST_ARB, ST_HOLD} state_e;

    state_e                             state_q, state_d;
    logic [PtrW-1:0]                    ptr_q, ptr_d;
    logic [PtrW-1:0]                    lock_win_q, lock_win_d;
    logic [IdWidth-1:0]                 lock_id_q, lock_id_d;

    logic [NumEntries-1:0]              valid_q, valid_d;
    logic [NumEntries-1:0][AddrWidth-1:0] addr_q, addr_d;
    logic [NumEntries-1:0][NumInp-1:0]  waiters_q, waiters_d;

    logic [NumEntries-1:0]              freeing;
    logic [NumInp-1:0]                  busy_req;
    logic [NumInp-1:0]                  elig;
    logic                               found;
    logic [PtrW-1:0]                    win;
    logic [AddrWidth-1:0]               addr_win;
    logic                               hit;
    logic [IdWidth-1:0]                 hit_id;
    logic                               have_free;
    logic [IdWidth-1:0]                 free_id;
    logic                               merge;
    logic                               accept;
    logic                               issue_hs;

    // Entry being completed this cycle: neither a merge target nor blocking
    // allocation, and its waiters are reported on rsp_done_o.
    always_comb begin
        freeing    = '0;
        rsp_done_o = '0;
        busy_req   = '0;
        for (int e = 0; e < NumEntries; e++) begin
            if (valid_q[e]) begin
                busy_req = busy_req | waiters_q[e];
                if (rsp_valid_i && rsp_id_i == IdWidth'(e)) begin
                    freeing[e] = 1'b1;
                    rsp_done_o = rsp_done_o | waiters_q[e];
                end
            end
        end
        if (rst_i) begin
            rsp_done_o = '0;
        end
    end

    // Waiters of an entry freed this cycle still count as busy, so they only
    // become eligible the cycle after the completion.
    assign elig = inp_valid_i & ~busy_req;

    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        if (state_q == ST_HOLD) begin
            win   = lock_win_q;
            found = inp_valid_i[lock_win_q];
        end else begin
            for (int k = 0; k < NumInp; k++) begin
                idx = (int'(ptr_q) + k) % NumInp;
                if (!found && elig[idx]) begin
                    found = 1'b1;
                    win   = PtrW'(idx);
                end
            end
        end
    end

    assign addr_win = inp_addr_i[win];

    always_comb begin
        hit       = 1'b0;
        hit_id    = '0;
        have_free = 1'b0;
        free_id   = '0;
        for (int e = 0; e < NumEntries; e++) begin
            if (!hit && valid_q[e] && !freeing[e] && addr_q[e] == addr_win) begin
                hit    = 1'b1;
                hit_id = IdWidth'(e);
            end
            if (!have_free && (!valid_q[e] || freeing[e])) begin
                have_free = 1'b1;
                free_id   = IdWidth'(e);
            end
        end
    end

    // Output decode. oup_valid_o never depends on oup_ready_i.
    always_comb begin
        inp_ready_o = '0;
        oup_valid_o = 1'b0;
        oup_id_o    = '0;
        oup_addr_o  = addr_win;
        merge       = 1'b0;
        if (!rst_i && found) begin
            if (state_q == ST_HOLD) begin
                oup_valid_o      = 1'b1;
                oup_id_o         = lock_id_q;
                inp_ready_o[win] = oup_ready_i;
            end else if (hit) begin
                merge            = 1'b1;
                inp_ready_o[win] = 1'b1;
            end else if (have_free) begin
                oup_valid_o      = 1'b1;
                oup_id_o         = free_id;
                inp_ready_o[win] = oup_ready_i;
            end
        end
    end

    assign accept   = |inp_ready_o;
    assign issue_hs = oup_valid_o & oup_ready_i;
    assign busy_o   = |valid_q;

    always_comb begin
        valid_d    = valid_q;
        addr_d     = addr_q;
        waiters_d  = waiters_q;
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_win_d = lock_win_q;
        lock_id_d  = lock_id_q;

        for (int e = 0; e < NumEntries; e++) begin
            if (freeing[e]) begin
                valid_d[e]   = 1'b0;
                waiters_d[e] = '0;
            end
        end
        if (merge) begin
            waiters_d[hit_id][win] = 1'b1;
        end
        // Allocation may reuse the entry freed this cycle, so it wins.
        if (issue_hs) begin
            valid_d[oup_id_o]        = 1'b1;
            addr_d[oup_id_o]         = addr_win;
            waiters_d[oup_id_o]      = '0;
            waiters_d[oup_id_o][win] = 1'b1;
        end

        if (accept) begin
            ptr_d = (int'(win) == NumInp - 1) ? '0 : PtrW'(int'(win) + 1);
        end

        if (oup_valid_o && !oup_ready_i) begin
            state_d    = ST_HOLD;
            lock_win_d = win;
            lock_id_d  = oup_id_o;
        end else begin
            state_d = ST_ARB;
        end

        if (flush_i) begin
            state_d = ST_ARB;
            ptr_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_ARB;
            ptr_q      <= '0;
            lock_win_q <= '0;
            lock_id_q  <= '0;
            valid_q    <= '0;
            addr_q     <= '0;
            waiters_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_win_q <= lock_win_d;
            lock_id_q  <= lock_id_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            waiters_q  <= waiters_d;
        end
    end

endmodule

// File: tb/tb_refill_merge_arb.sv
// ---------------------------------------------------------------------------
// tb_refill_merge_arb
//
// Directed stimulus against refill_merge_arb with default parameters
// (4 requesters, 4 entries, 32-bit addresses). Inputs change 1 time unit
// after the rising edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_refill_merge_arb;

    localparam int NI = 4;
    localparam int AW = 32;
    localparam int NE = 4;
    localparam int IW = 2;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    flush_i;
    logic [NI-1:0][AW-1:0]   inp_addr_i;
    logic [NI-1:0]           inp_valid_i;
    logic [NI-1:0]           inp_ready_o;
    logic [AW-1:0]           oup_addr_o;
    logic [IW-1:0]           oup_id_o;
    logic                    oup_valid_o;
    logic                    oup_ready_i;
    logic                    rsp_valid_i;
    logic [IW-1:0]           rsp_id_i;
    logic [NI-1:0]           rsp_done_o;
    logic                    busy_o;

    int checks = 0;
    int errors = 0;

    refill_merge_arb #(
        .NumInp     (NI),
        .AddrWidth  (AW),
        .NumEntries (NE)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .inp_addr_i  (inp_addr_i),
        .inp_valid_i (inp_valid_i),
        .inp_ready_o (inp_ready_o),
        .oup_addr_o  (oup_addr_o),
        .oup_id_o    (oup_id_o),
        .oup_valid_o (oup_valid_o),
        .oup_ready_i (oup_ready_i),
        .rsp_valid_i (rsp_valid_i),
        .rsp_id_i    (rsp_id_i),
        .rsp_done_o  (rsp_done_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Check the whole combinational handshake picture in one go.
    task automatic chk_out(input string tag, input logic [3:0] rdy, input logic ov,
                           input logic [1:0] id, input logic [31:0] addr);
        chk({tag, ".ready"}, 64'(inp_ready_o), 64'(rdy));
        chk({tag, ".oval"},  64'(oup_valid_o), 64'(ov));
        if (ov) begin
            chk({tag, ".id"},   64'(oup_id_o),   64'(id));
            chk({tag, ".addr"}, 64'(oup_addr_o), 64'(addr));
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        inp_valid_i = 4'b1111;
        inp_addr_i  = '0;
        oup_ready_i = 1'b1;
        rsp_valid_i = 1'b0;
        rsp_id_i    = '0;

        // Reset with requests pending: nothing may be accepted.
        settle();
        chk_out("rst_comb", 4'b0000, 1'b0, 2'd0, 32'h0);
        step();
        step();
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(rsp_done_o), 64'd0);
        rst_i       = 1'b0;
        inp_valid_i = '0;
        settle();
        chk_out("idle", 4'b0000, 1'b0, 2'd0, 32'h0);
        chk("idle_busy", 64'(busy_o), 64'd0);

        // Single miss issue.
        inp_valid_i   = 4'b0001;
        inp_addr_i[0] = 32'h100;
        settle();
        chk_out("miss0", 4'b0001, 1'b1, 2'd0, 32'h100);
        step();
        inp_valid_i = '0;
        settle();
        chk("miss0_busy", 64'(busy_o), 64'd1);

        // Merge into entry 0, then complete it.
        inp_valid_i   = 4'b0010;
        inp_addr_i[1] = 32'h100;
        settle();
        chk_out("merge1", 4'b0010, 1'b0, 2'd0, 32'h0);
        step();
        inp_valid_i = '0;
        rsp_valid_i = 1'b1;
        rsp_id_i    = 2'd0;
        settle();
        chk("rsp0_done", 64'(rsp_done_o), 64'b0011);
        step();
        rsp_valid_i = 1'b0;
        settle();
        chk("rsp0_pulse", 64'(rsp_done_o), 64'd0);
        chk("rsp0_busy", 64'(busy_o), 64'd0);

        // Flush pointer (now 2) back to 0, then four distinct misses.
        flush_i = 1'b1;
        step();
        flush_i       = 1'b0;
        inp_addr_i[0] = 32'h200;
        inp_addr_i[1] = 32'h300;
        inp_addr_i[2] = 32'h400;
        inp_addr_i[3] = 32'h500;
        inp_valid_i   = 4'b1111;
        settle();
        chk_out("rr0", 4'b0001, 1'b1, 2'd0, 32'h200);
        step();
        inp_valid_i = 4'b1110;
        settle();
        chk_out("rr1", 4'b0010, 1'b1, 2'd1, 32'h300);
        step();
        inp_valid_i = 4'b1100;
        settle();
        chk_out("rr2", 4'b0100, 1'b1, 2'd2, 32'h400);
        step();
        inp_valid_i = 4'b1000;
        settle();
        chk_out("rr3", 4'b1000, 1'b1, 2'd3, 32'h500);
        step();

        // Requester 0 comes back with a new line while it still has a miss.
        inp_valid_i   = 4'b0001;
        inp_addr_i[0] = 32'h600;
        settle();
        chk_out("stall_a", 4'b0000, 1'b0, 2'd0, 32'h0);
        chk("full_busy", 64'(busy_o), 64'd1);
        step();
        settle();
        chk_out("stall_b", 4'b0000, 1'b0, 2'd0, 32'h0);
        rsp_valid_i = 1'b1;
        rsp_id_i    = 2'd0;
        settle();
        chk("rsp_e0", 64'(rsp_done_o), 64'b0001);
        chk_out("stall_rsp", 4'b0000, 1'b0, 2'd0, 32'h0);
        step();
        rsp_valid_i = 1'b0;
        settle();
        chk_out("reissue0", 4'b0001, 1'b1, 2'd0, 32'h600);
        step();
        inp_valid_i = '0;

        // Free entry 1, then a same-cycle response and matching address.
        rsp_valid_i = 1'b1;
        rsp_id_i    = 2'd1;
        settle();
        chk("rsp_e1", 64'(rsp_done_o), 64'b0010);
        step();
        rsp_id_i      = 2'd0;
        inp_valid_i   = 4'b0010;
        inp_addr_i[1] = 32'h600;
        settle();
        chk("rsp_e0b", 64'(rsp_done_o), 64'b0001);
        chk_out("nomerge", 4'b0010, 1'b1, 2'd0, 32'h600);
        step();
        inp_valid_i = '0;
        settle();
        chk("realloc_e0", 64'(rsp_done_o), 64'b0010);
        step();
        rsp_id_i = 2'd2;
        settle();
        chk("rsp_e2", 64'(rsp_done_o), 64'b0100);
        step();
        rsp_id_i = 2'd3;
        settle();
        chk("rsp_e3", 64'(rsp_done_o), 64'b1000);
        step();
        rsp_valid_i = 1'b0;
        settle();
        chk("empty_busy", 64'(busy_o), 64'd0);

        // Downstream stall: pointer is 2, so requester 2 wins and holds.
        inp_valid_i   = 4'b1100;
        inp_addr_i[2] = 32'h700;
        inp_addr_i[3] = 32'h800;
        oup_ready_i   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk_out("hold", 4'b0000, 1'b1, 2'd0, 32'h700);
            step();
        end
        oup_ready_i = 1'b1;
        settle();
        chk_out("hold_rel", 4'b0100, 1'b1, 2'd0, 32'h700);
        step();
        inp_valid_i = 4'b1000;
        settle();
        chk_out("after_hold", 4'b1000, 1'b1, 2'd1, 32'h800);
        step();
        inp_valid_i = '0;

        // Response to an invalid entry is ignored.
        rsp_valid_i = 1'b1;
        rsp_id_i    = 2'd3;
        settle();
        chk("rsp_inval", 64'(rsp_done_o), 64'd0);
        step();
        rsp_valid_i = 1'b0;
        settle();
        chk("inval_busy", 64'(busy_o), 64'd1);

        // Reset while locked (entries 0 and 1 busy, so id 2).
        inp_valid_i   = 4'b0001;
        inp_addr_i[0] = 32'h900;
        oup_ready_i   = 1'b0;
        settle();
        chk_out("lock_pre", 4'b0000, 1'b1, 2'd2, 32'h900);
        step();
        rst_i       = 1'b1;
        inp_valid_i = '0;
        step();
        rst_i = 1'b0;
        settle();
        chk_out("post_rst", 4'b0000, 1'b0, 2'd0, 32'h0);
        chk("post_rst_busy", 64'(busy_o), 64'd0);
        chk("post_rst_done", 64'(rsp_done_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/refill_merge_arb.md
REFILL_MERGE_ARB -- requirements
Module: refill_merge_arb

Interface
REQ-001 Parameters SHALL be:
- NumInp, default 4, number of requesters (≥1).
- AddrWidth, default 32, cache-line address width.
- NumEntries, default 4, outstanding-miss table depth (≥1).
- IdWidth = max(1, clog2(NumEntries)), derived.
REQ-002 Ports SHALL be:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  clears arbiter lock and round-robin pointer.
- inp_addr_i  in  NumInp×AddrWidth  per-requester line address.
- inp_valid_i  in  NumInp  per-requester request valid.
- inp_ready_o  out  NumInp  per-requester accept.
- oup_addr_o  out  AddrWidth  downstream refill address.
- oup_id_o  out  IdWidth  table entry tagging the refill.
- oup_valid_o  out  1  downstream request valid.
- oup_ready_i  in  1  downstream accept.
- rsp_valid_i  in  1  refill-complete strobe.
- rsp_id_i  in  IdWidth  entry of the completed refill.
- rsp_done_o  out  NumInp  one-cycle completion pulse per waiting requester.
- busy_o  out  1  any table entry valid.
REQ-003 Reset SHALL be synchronous and active-high on rst_i, sampled on the rising edge of clk_i only.

Function
REQ-004 Table: NumEntries entries, each {valid, addr, waiters[NumInp]}.
REQ-005 A requester i is eligible when inp_valid_i[i]=1 and bit i is clear in every valid entry's waiter mask (at most one outstanding miss per requester).
REQ-006 Round-robin arbitration over eligible requesters; search starts at pointer; pointer advances to winner+1 (mod NumInp) on every accept (merge or issue).
REQ-007 Matching: a winner hits when its address equals addr of a valid entry not being freed this cycle (rsp_valid_i with rsp_id_i = that entry).
REQ-008 Hit (merge): inp_ready_o[winner]=1 combinationally same cycle; winner bit set in that entry's waiters next edge; oup_valid_o=0 for this decision.
REQ-009 Miss with free entry: oup_valid_o=1 combinationally; oup_addr_o = winner address; oup_id_o = lowest-index free entry; inp_ready_o[winner] = oup_ready_i.
REQ-010 On miss handshake (oup_valid_o & oup_ready_i): allocate entry with valid=1, addr, waiters = onehot(winner) at next edge.
REQ-011 Lock: if oup_valid_o=1 and oup_ready_i=0, winner, addr and id SHALL be held unchanged next cycle. Requester must hold valid and address; merges of other requesters are blocked while locked.
REQ-012 Miss with table full: no accept, oup_valid_o=0, pointer unchanged.
REQ-013 Response: on rsp_valid_i, rsp_done_o = waiters of entry rsp_id_i for exactly that cycle (combinational); entry cleared at next edge.
- rsp_valid_i on an invalid entry: rsp_done_o=0, no state change.
REQ-014 An entry freed by a response is free for allocation in the same cycle only if lowest index; its waiters become eligible the following cycle.
REQ-015 At most one accept per cycle; inp_ready_o is onehot or zero.
REQ-016 busy_o = OR of entry valid bits (registered state).
REQ-017 flush_i clears lock and resets pointer to 0; table contents preserved; takes priority over lock update.
REQ-018 Zero-cycle latency input→output; rsp→rsp_done_o combinational; no combinational path oup_ready_i→oup_valid_o.

Reset
REQ-019 On rst_i: all entries invalid, waiters 0, pointer 0, lock 0.
REQ-020 During and after reset: oup_valid_o=0, inp_ready_o=0, rsp_done_o=0, busy_o=0 until valid inputs arrive; reset mid-lock drops the held request.

Verification
REQ-021 Req0 addr 0x100, oup_ready_i=1 -> oup_valid_o=1, oup_id_o=0, inp_ready_o=0001; next cycle busy_o=1.
REQ-022 Req1 addr 0x100 while entry 0 holds 0x100 -> inp_ready_o=0010, oup_valid_o=0; rsp id 0 -> rsp_done_o=0011 for one cycle, busy_o=0 next cycle.
REQ-023 All 4 requesters valid, distinct addrs, oup_ready_i=1 -> grants in order 0,1,2,3 on ids 0,1,2,3; 5th distinct request from released requester stalls until a response arrives.
REQ-024 oup_ready_i=0 for 3 cycles with req2 and req3 valid -> oup_addr_o/oup_id_o stable, winner unchanged; ready=1 -> inp_ready_o[2]=1 only.
REQ-025 Same-cycle rsp id 0 and req matching entry 0 addr -> no merge, treated as miss, issued with oup_id_o=0.
REQ-026 rst_i asserted while locked -> next cycle all outputs 0, busy_o=0.
